instruction_fetch: RTL
======================

# instruction_fetch

Instruction-fetch stage feeding the decode/operand-fetch stage. It owns the program counter, issues word reads to instruction memory, and buffers returned words in a 2-entry prefetch FIFO. It presents each instruction as `ir` together with `pc_1`, the address of that instruction plus one, and handles decode-stage stalls and branch/jump redirects.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_IR`, 32'h0000_0000, instruction word driven on `ir` during a bubble.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_addr`  out  16  word address of the current request; equals the PC register.
- `imem_req`  out  1  one read request per high cycle; memory always accepts.
- `imem_data`  in  32  returned instruction word.
- `imem_valid`  in  1  `imem_data` is valid. Responses are in order, with latency ≥1 cycle.
- `stall`  in  1  decode stage cannot accept a new instruction; hold the output.
- `redirect`  in  1  taken branch or jump, one-cycle pulse.
- `redirect_pc`  in  16  target address, sampled when `redirect`=1.
- `ir`  out  32  instruction to decode.
- `pc_1`  out  16  fetched address + 1, mod 2^16.
- `ir_valid`  out  1  `ir`/`pc_1` hold a real instruction (0 = bubble).

## Operation
- State:
  - `pc` (16b).
  - FIFO of {addr+1, word}, depth 2, with `count` 0..2.
  - `outstanding` 0..2 (requests issued but not yet answered).
  - `drop` 0..2 (responses still to be discarded).
  - Output latch {`ir`, `pc_1`, `ir_valid`}.
- Issue rule: `imem_req` = !`redirect` && (`count` + `outstanding` < 2). This is combinational.
- On issue:
  - `pc` <= `pc`+1; wraps 16'hFFFF -> 16'h0000.
  - Push the issue address onto an internal 2-entry address queue, so that address+1 can be paired with the returning word.
- Response with `drop`>0: the word is discarded, `drop`--, and `outstanding`--.
- Response with `drop`=0: the word is written into the FIFO, or bypassed (see below), and `outstanding`--.
- Output latch update, evaluated each edge:
  - `redirect`=1: latch loads a bubble, whatever `stall` is.
  - `stall`=1 and no redirect: latch holds.
  - Otherwise, FIFO non-empty: pop the head into the latch, `ir_valid`=1.
  - Otherwise, FIFO empty but a non-dropped response arrives: bypass it into the latch.
  - Otherwise: bubble (`ir`=`NOP_IR`, `ir_valid`=0, `pc_1` holds).
- Redirect, on the edge where `redirect`=1:
  - `pc` <= `redirect_pc`.
  - FIFO and address queue are flushed.
  - `drop` <= `outstanding` minus 1 if `imem_valid` is high in the same cycle (that response is discarded too).
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - Push and pop on the same edge leave `count` unchanged.
  - Issue and response on the same edge leave `outstanding` unchanged.
- The design never overflows: the credit rule guarantees `count` + `outstanding` ≤ 2.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=1 combinationally once `rst` is low (credit available).
  - `ir`=`NOP_IR`, `pc_1`=16'h0000, `ir_valid`=0.
  - `count`=`outstanding`=`drop`=0.
- Latency: a request in cycle n with a response in n+1 gives `ir_valid`=1 in cycle n+2 via the bypass.
- Throughput: one instruction per cycle with latency-1 memory and no stall.
- Under `stall`, at most 2 further words are accepted, then `imem_req` drops to 0. After `stall` deasserts, the FIFO drains one word per cycle and issue resumes.
- Redirect penalty: the target is requested in cycle r+1; with latency-1 memory its `ir` appears in cycle r+3. `ir_valid`=0 in cycles r+1 and r+2.
- Asserting `rst` mid-operation clears all state immediately. Responses to requests issued before reset must not be sent by memory; memory is reset on the same `rst`.

## Test plan
- Reset, then latency-1 memory returning word = 32'hA000_0000+addr -> `imem_addr` 0,1,2,... in consecutive cycles. From cycle 2: `ir`=A0000000, A0000001, ... with `pc_1`=1, 2, ... and `ir_valid` continuously 1.
- `stall` held 4 cycles during streaming -> `ir` and `pc_1` frozen. `imem_req` low after 2 more words. After release, the next two `ir` values come from the FIFO in order with no gaps, skips or duplicates.
- Memory latency 3 with `redirect`=1, `redirect_pc`=16'h0040, while 2 requests are outstanding -> both late responses discarded. The next valid `ir` is word 0x0040 with `pc_1`=16'h0041, and bubbles carry `ir`=`NOP_IR`.
- `redirect` asserted while `stall`=1 -> the latch becomes a bubble in the same edge and the stalled instruction is squashed.
- `redirect_pc`=16'hFFFF -> `imem_addr` FFFF then 0000. `pc_1` for word FFFF is 16'h0000.
- `rst` asserted asynchronously mid-stream with a full FIFO -> all outputs return to their reset values immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the program counter, issues one-word reads to
// instruction memory, buffers returned words in a 2-entry prefetch FIFO and
// presents {ir, pc_1, ir_valid} to decode, honouring stalls and redirects.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [31:0] ir,
    output logic [15:0] pc_1,
    output logic        ir_valid
);

    logic [15:0] pc;
    logic [1:0]  count;
    logic [1:0]  outstanding;
    logic [1:0]  drop;

    // Addresses of live (non-dropped) requests, oldest at aq_head
    logic [15:0] aq_addr [2];
    logic        aq_head;
    logic        aq_tail;

    // Prefetch FIFO of {address+1, word}, oldest at fq_head
    logic [15:0] fq_pc1  [2];
    logic [31:0] fq_word [2];
    logic        fq_head;
    logic        fq_tail;

    logic [2:0]  credit_used;
    logic        issue;
    logic        resp_live;
    logic        resp_drop;
    logic        resp_take;
    logic [15:0] resp_pc1;
    logic        advance;
    logic        pop;
    logic        bypass;
    logic        push;

    // Credit-based issue and routing of the returning word (FIFO, bypass or discard)
    always_comb begin
        credit_used = {1'b0, count} + {1'b0, outstanding};
        issue       = !redirect && (credit_used < 3'd2);
        resp_live   = imem_valid && (drop == 2'd0);
        resp_drop   = imem_valid && (drop != 2'd0);
        resp_take   = resp_live && !redirect;
        resp_pc1    = aq_addr[aq_head] + 16'd1;
        advance     = !redirect && !stall;
        pop         = advance && (count != 2'd0);
        bypass      = advance && (count == 2'd0) && resp_take;
        push        = resp_take && !bypass;
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    // Program counter: redirect target wins, otherwise advance on every issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (issue) begin
            pc <= pc + 16'd1;
        end
    end

    // Requests in flight: +1 per issue, -1 per response of any kind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue, imem_valid})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Responses to discard: everything still in flight when a redirect is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= '0;
        end else if (redirect) begin
            // A response arriving in the redirect cycle is discarded right now,
            // so it is not counted again.
            drop <= outstanding - {1'b0, imem_valid};
        end else if (resp_drop) begin
            drop <= drop - 2'd1;
        end
    end

    // Address queue: pairs each live response with the address it was issued for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_addr[0] <= '0;
            aq_addr[1] <= '0;
            aq_head    <= 1'b0;
            aq_tail    <= 1'b0;
        end else if (redirect) begin
            aq_head <= 1'b0;
            aq_tail <= 1'b0;
        end else begin
            if (issue) begin
                aq_addr[aq_tail] <= pc;
                aq_tail          <= ~aq_tail;
            end
            if (resp_live) begin
                aq_head <= ~aq_head;
            end
        end
    end

    // Prefetch FIFO: holds words that decode could not take yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fq_pc1[0]  <= '0;
            fq_pc1[1]  <= '0;
            fq_word[0] <= '0;
            fq_word[1] <= '0;
            fq_head    <= 1'b0;
            fq_tail    <= 1'b0;
            count      <= '0;
        end else if (redirect) begin
            fq_head <= 1'b0;
            fq_tail <= 1'b0;
            count   <= '0;
        end else begin
            if (push) begin
                fq_pc1[fq_tail]  <= resp_pc1;
                fq_word[fq_tail] <= imem_data;
                fq_tail          <= ~fq_tail;
            end
            if (pop) begin
                fq_head <= ~fq_head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Output latch: bubble on redirect, hold on stall, else FIFO head, bypass or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= NOP_IR;
            pc_1     <= '0;
            ir_valid <= 1'b0;
        end else if (redirect) begin
            ir       <= NOP_IR;
            ir_valid <= 1'b0;
        end else if (!stall) begin
            if (count != 2'd0) begin
                ir       <= fq_word[fq_head];
                pc_1     <= fq_pc1[fq_head];
                ir_valid <= 1'b1;
            end else if (resp_take) begin
                ir       <= imem_data;
                pc_1     <= resp_pc1;
                ir_valid <= 1'b1;
            end else begin
                ir       <= NOP_IR;
                ir_valid <= 1'b0;
            end
        end
    end

endmodule
